// File: rtl/sweep_pkg.sv
// Shared types and sizing helpers for the DAC sweep generator.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN
    } sweep_state_e;

    localparam int ACC_GUARD = 1;

    function automatic int acc_width(input int sig_w, input int frac_w);
        return sig_w + frac_w + ACC_GUARD;
    endfunction

endpackage

// File: rtl/sweep_step_unit.sv
// Combinational accumulator step: add or subtract the step, then clamp against a limit.
module sweep_step_unit
    import sweep_pkg::*;
#(
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int ACC_FRAC        = 16
) (
    input  logic signed [acc_width(SIGNAL_OUT_SIZE, ACC_FRAC)-1:0] acc_in,
    input  logic        [31:0]                                     step_in,
    input  logic signed [SIGNAL_OUT_SIZE-1:0]                      limit_in,
    input  logic                                                   sub_in,
    output logic signed [acc_width(SIGNAL_OUT_SIZE, ACC_FRAC)-1:0] acc_out,
    output logic                                                   hit_out
);

    localparam int AW = acc_width(SIGNAL_OUT_SIZE, ACC_FRAC);
    // The sum is widened so even a full 32-bit step cannot wrap before the compare.
    localparam int SW = AW + 32;
    localparam int IW = SW - ACC_FRAC;
    localparam int LW = AW - ACC_FRAC;

    logic signed [SW-1:0] acc_sx;
    logic signed [SW-1:0] step_sx;
    logic signed [SW-1:0] sum;
    logic signed [IW-1:0] sum_int;
    logic signed [IW-1:0] lim_int;
    logic signed [AW-1:0] lim_acc;

    always_comb begin
        acc_sx  = SW'(acc_in);
        step_sx = SW'(step_in);
        sum     = sub_in ? (acc_sx - step_sx) : (acc_sx + step_sx);
        sum_int = sum[SW-1:ACC_FRAC];
        lim_int = IW'(limit_in);
        lim_acc = {LW'(limit_in), {ACC_FRAC{1'b0}}};
        hit_out = sub_in ? (sum_int <= lim_int) : (sum_int >= lim_int);
        acc_out = hit_out ? lim_acc : sum[AW-1:0];
    end

endmodule

// File: rtl/dac_sweep_gen.sv
// Programmable ramp source for one AD9783 DAC channel word.
// SWEEP_TRIANGLE_EN selects a triangle sweep; undefined builds a sawtooth.
module dac_sweep_gen
    import sweep_pkg::*;
#(
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int ACC_FRAC        = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              on_in,
    input  logic signed [SIGNAL_OUT_SIZE-1:0] minval_in,
    input  logic signed [SIGNAL_OUT_SIZE-1:0] maxval_in,
    input  logic        [31:0]                stepsize_in,
    output logic signed [SIGNAL_OUT_SIZE-1:0] signal_out,
    output logic                              sync_out,
    output logic                              dir_out
);

    localparam int AW = acc_width(SIGNAL_OUT_SIZE, ACC_FRAC);
    localparam int LW = AW - ACC_FRAC;

    function automatic logic signed [AW-1:0] code_to_acc(input logic signed [SIGNAL_OUT_SIZE-1:0] c);
        return {LW'(c), {ACC_FRAC{1'b0}}};
    endfunction

    sweep_state_e                      state_q, state_d;
    logic signed [AW-1:0]              acc_q, acc_d;
    logic signed [SIGNAL_OUT_SIZE-1:0] signal_q, signal_d;
    logic                              sync_q, sync_d;
    logic signed [SIGNAL_OUT_SIZE-1:0] min_l_q, min_l_d;
    logic signed [SIGNAL_OUT_SIZE-1:0] max_l_q, max_l_d;
    logic        [31:0]                step_l_q, step_l_d;
`ifdef SWEEP_TRIANGLE_EN
    logic                              dir_q, dir_d;
`else
    logic                              top_q, top_d;
`endif

    logic signed [AW-1:0]              nxt_acc;
    logic                              nxt_hit;
    logic                              step_sub;

    assign step_sub = (state_q == ST_DOWN);

    sweep_step_unit #(
        .SIGNAL_OUT_SIZE(SIGNAL_OUT_SIZE),
        .ACC_FRAC       (ACC_FRAC)
    ) u_step (
        .acc_in  (acc_q),
        .step_in (step_l_q),
        .limit_in(step_sub ? min_l_q : max_l_q),
        .sub_in  (step_sub),
        .acc_out (nxt_acc),
        .hit_out (nxt_hit)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        signal_d = signal_q;
        sync_d   = 1'b0;
        min_l_d  = min_l_q;
        max_l_d  = max_l_q;
        step_l_d = step_l_q;
`ifdef SWEEP_TRIANGLE_EN
        dir_d    = dir_q;
`else
        top_d    = 1'b0;
`endif
        if (!on_in || state_q == ST_IDLE) begin
            state_d  = ST_IDLE;
            signal_d = minval_in;
            acc_d    = code_to_acc(minval_in);
`ifdef SWEEP_TRIANGLE_EN
            dir_d    = 1'b1;
`endif
            if (on_in && (minval_in < maxval_in)) begin
                state_d  = ST_UP;
                sync_d   = 1'b1;
                min_l_d  = minval_in;
                max_l_d  = maxval_in;
                step_l_d = stepsize_in;
            end
        end else begin
            case (state_q)
                ST_UP: begin
`ifndef SWEEP_TRIANGLE_EN
                    // Sawtooth wrap: one cycle after the max sample, restart the period.
                    if (top_q) begin
                        signal_d = min_l_q;
                        acc_d    = code_to_acc(min_l_q);
                        sync_d   = 1'b1;
                        min_l_d  = minval_in;
                        max_l_d  = maxval_in;
                        step_l_d = stepsize_in;
                    end else
`endif
                    begin
                        acc_d    = nxt_acc;
                        signal_d = nxt_acc[AW-2:ACC_FRAC];
                        if (nxt_hit) begin
`ifdef SWEEP_TRIANGLE_EN
                            state_d = ST_DOWN;
`else
                            top_d   = 1'b1;
`endif
                        end
                    end
                end
`ifdef SWEEP_TRIANGLE_EN
                ST_DOWN: begin
                    acc_d    = nxt_acc;
                    signal_d = nxt_acc[AW-2:ACC_FRAC];
                    dir_d    = 1'b0;
                    if (nxt_hit) begin
                        state_d  = ST_UP;
                        dir_d    = 1'b1;
                        sync_d   = 1'b1;
                        min_l_d  = minval_in;
                        max_l_d  = maxval_in;
                        step_l_d = stepsize_in;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            signal_q <= '0;
            sync_q   <= 1'b0;
            min_l_q  <= '0;
            max_l_q  <= '0;
            step_l_q <= '0;
`ifdef SWEEP_TRIANGLE_EN
            dir_q    <= 1'b1;
`else
            top_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            signal_q <= signal_d;
            sync_q   <= sync_d;
            min_l_q  <= min_l_d;
            max_l_q  <= max_l_d;
            step_l_q <= step_l_d;
`ifdef SWEEP_TRIANGLE_EN
            dir_q    <= dir_d;
`else
            top_q    <= top_d;
`endif
        end
    end

    assign signal_out = signal_q;
    assign sync_out   = sync_q;
`ifdef SWEEP_TRIANGLE_EN
    assign dir_out    = dir_q;
`else
    assign dir_out    = 1'b1;
`endif

endmodule

// File: tb/tb_dac_sweep_gen.sv
// Directed scoreboard bench for dac_sweep_gen (triangle or sawtooth per SWEEP_TRIANGLE_EN).
module tb_dac_sweep_gen;

    logic               clk_in;
    logic               rst_n_in;
    logic               on_in;
    logic signed [15:0] minval_in;
    logic signed [15:0] maxval_in;
    logic        [31:0] stepsize_in;
    logic signed [15:0] signal_out;
    logic               sync_out;
    logic               dir_out;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic signed [15:0] sig;
        logic               sync;
        logic               dir;
    } exp_t;

    exp_t sb[$];

    dac_sweep_gen #(
        .SIGNAL_OUT_SIZE(16),
        .ACC_FRAC       (16)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .on_in      (on_in),
        .minval_in  (minval_in),
        .maxval_in  (maxval_in),
        .stepsize_in(stepsize_in),
        .signal_out (signal_out),
        .sync_out   (sync_out),
        .dir_out    (dir_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push the expected sample, advance one edge, then pop and compare.
    task automatic expect_edge(input string tag, input logic signed [15:0] s,
                               input logic sy, input logic d);
        exp_t e;
        e.sig  = s;
        e.sync = sy;
        e.dir  = d;
        sb.push_back(e);
        @(posedge clk_in);
        #1;
        e = sb.pop_front();
        chk({tag, ".sig"},  32'(signal_out), 32'(e.sig));
        chk({tag, ".sync"}, 32'(sync_out),   32'(e.sync));
        chk({tag, ".dir"},  32'(dir_out),    32'(e.dir));
    endtask

    initial begin
        rst_n_in    = 1'b0;
        on_in       = 1'b1;
        minval_in   = 16'sd0;
        maxval_in   = 16'sd4;
        stepsize_in = 32'h0001_0000;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst.sig",  32'(signal_out), 32'h0);
        chk("rst.sync", 32'(sync_out),   32'h0);
        chk("rst.dir",  32'(dir_out),    32'h1);

        rst_n_in = 1'b1;
        expect_edge("start", 16'sd0, 1'b1, 1'b1);
        for (int c = 1; c <= 4; c++) expect_edge("ramp_up", 16'(c), 1'b0, 1'b1);
`ifdef SWEEP_TRIANGLE_EN
        for (int c = 3; c >= 1; c--) expect_edge("ramp_down", 16'(c), 1'b0, 1'b0);
        expect_edge("tri_period", 16'sd0, 1'b1, 1'b1);
`else
        expect_edge("saw_period", 16'sd0, 1'b1, 1'b1);
`endif
        for (int c = 1; c <= 3; c++) expect_edge("ramp_up2", 16'(c), 1'b0, 1'b1);

        on_in = 1'b0;
        expect_edge("drop", 16'sd0, 1'b0, 1'b1);
        expect_edge("idle_hold", 16'sd0, 1'b0, 1'b1);
        on_in = 1'b1;
        expect_edge("restart", 16'sd0, 1'b1, 1'b1);
        expect_edge("restart_up", 16'sd1, 1'b0, 1'b1);

        rst_n_in = 1'b0;
        #1;
        chk("async_rst.sig",  32'(signal_out), 32'h0);
        chk("async_rst.sync", 32'(sync_out),   32'h0);
        chk("async_rst.dir",  32'(dir_out),    32'h1);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        expect_edge("post_rst", 16'sd0, 1'b1, 1'b1);

        on_in     = 1'b0;
        minval_in = 16'sd5;
        maxval_in = 16'sd5;
        expect_edge("eq_idle", 16'sd5, 1'b0, 1'b1);
        on_in = 1'b1;
        repeat (3) expect_edge("eq_on", 16'sd5, 1'b0, 1'b1);

        minval_in   = 16'sh7FF0;
        maxval_in   = 16'sh7FFF;
        stepsize_in = 32'h0010_0000;
        expect_edge("edge_start", 16'sh7FF0, 1'b1, 1'b1);
        expect_edge("edge_clamp", 16'sh7FFF, 1'b0, 1'b1);
        expect_edge("edge_wrap",  16'sh7FF0, 1'b1, 1'b1);
        expect_edge("edge_clamp2", 16'sh7FFF, 1'b0, 1'b1);

        on_in       = 1'b0;
        minval_in   = 16'sd0;
        maxval_in   = 16'sd2;
        stepsize_in = 32'h0000_0200;
        expect_edge("frac_idle", 16'sd0, 1'b0, 1'b1);
        on_in = 1'b1;
        expect_edge("frac_start", 16'sd0, 1'b1, 1'b1);
        for (int i = 0; i < 127; i++) expect_edge("frac_hold0", 16'sd0, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) expect_edge("frac_hold1a", 16'sd1, 1'b0, 1'b1);
        maxval_in = 16'sd10;
        for (int i = 0; i < 64; i++) expect_edge("frac_hold1b", 16'sd1, 1'b0, 1'b1);
        expect_edge("frac_top_old", 16'sd2, 1'b0, 1'b1);
`ifdef SWEEP_TRIANGLE_EN
        for (int i = 0; i < 128; i++) expect_edge("frac_down1", 16'sd1, 1'b0, 1'b0);
`endif
        expect_edge("frac_period2", 16'sd0, 1'b1, 1'b1);
        for (int i = 0; i < 127; i++) expect_edge("frac2_hold0", 16'sd0, 1'b0, 1'b1);
        for (int c = 1; c <= 9; c++)
            for (int i = 0; i < 128; i++) expect_edge("frac2_hold", 16'(c), 1'b0, 1'b1);
        expect_edge("frac2_top_new", 16'sd10, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
